// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: one-at-a-time sequencer for the shared multiply/divide units and HI/LO write ports
module muldiv_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [2:0] op_code,
  input  logic       divisor_zero,
  input  logic       div_busy,
  input  logic       divu_busy,
  output logic       op_ready,
  output logic       busy,
  output logic       mul_start,
  output logic       mulu_start,
  output logic       div_start,
  output logic       hi_wena,
  output logic [1:0] hi_select,
  output logic       lo_wena,
  output logic [1:0] lo_select,
  output logic       done,
  output logic [1:0] err_code
);
  typedef enum logic [2:0] {IDLE, ISSUE, MUL_WAIT, DIV_ARM, DIV_WAIT, WRITE, DONE} state_t;
  localparam logic [2:0] MULTU = 3'b000, DIVU = 3'b001, DIV = 3'b010, MTHI = 3'b011, MTLO = 3'b100, MUL = 3'b101;
  localparam logic [7:0] MUL_LOAD = 8'(MUL_LATENCY);
  localparam logic [7:0] DIV_LAST = 8'(DIV_TIMEOUT - 2);
  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] err_q, err_d;
  logic       is_div, sel_busy, wr;
  assign is_div   = (op_q == DIVU) || (op_q == DIV);
  assign sel_busy = (op_q == DIVU) ? divu_busy : div_busy;
  assign wr       = state_q == WRITE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      cnt_q   <= 8'd0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (op_valid) begin
        op_d = op_code;
        if (op_code == MTHI || op_code == MTLO) state_d = WRITE;
        else if ((op_code == DIVU || op_code == DIV) && divisor_zero) begin
          state_d = DONE;
          err_d   = 2'b01;
        end else if (op_code[2:1] == 2'b11) begin
          state_d = DONE;
          err_d   = 2'b11;
        end else state_d = ISSUE;
      end
      ISSUE: begin
        state_d = is_div ? DIV_ARM : MUL_WAIT;
        cnt_d   = is_div ? 8'd0 : MUL_LOAD;
      end
      MUL_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = (op_q == MULTU) ? WRITE : DONE;
      end
      DIV_ARM: state_d = DIV_WAIT;
      DIV_WAIT: if (!sel_busy) state_d = WRITE;
      else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == DIV_LAST) begin
          state_d = DONE;
          err_d   = 2'b10;
        end
      end
      WRITE: state_d = DONE;
      DONE: begin
        err_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign op_ready   = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign mul_start  = (state_q == ISSUE) && (op_q == MUL);
  assign mulu_start = (state_q == ISSUE) && (op_q == MULTU);
  assign div_start  = (state_q == ISSUE) && is_div;
  assign hi_wena    = wr && (op_q != MTLO);
  assign lo_wena    = wr && (op_q != MTHI);
  assign hi_select  = !wr ? 2'd0 : (op_q == MULTU) ? 2'd2 : (op_q == DIV) ? 2'd1 : (op_q == MTHI) ? 2'd3 : 2'd0;
  assign lo_select  = !wr ? 2'd0 : (op_q == MULTU) ? 2'd2 : (op_q == DIV) ? 2'd1 : (op_q == MTLO) ? 2'd3 : 2'd0;
  assign done       = state_q == DONE;
  assign err_code   = done ? err_q : 2'b00;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed cycle-by-cycle checks of the muldiv sequencer outputs
module tb_muldiv_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = 3'b000;
  logic       divisor_zero = 1'b0;
  logic       div_busy = 1'b0;
  logic       divu_busy = 1'b0;
  logic       op_ready, busy, mul_start, mulu_start, div_start, hi_wena, lo_wena, done;
  logic [1:0] hi_select, lo_select, err_code;
  logic [13:0] obs;
  int n_chk = 0;
  int n_fail = 0;
  // {op_ready, busy, mul_start, mulu_start, div_start, hi_wena, hi_select, lo_wena, lo_select, done, err_code}
  localparam logic [13:0] IDLE_V   = 14'b1_1_000_0_00_0_00_0_00 & 14'b1_0_111_1_11_1_11_1_11;
  localparam logic [13:0] BUSY_V   = 14'b0_1_000_0_00_0_00_0_00;
  localparam logic [13:0] MULU_S   = 14'b0_1_010_0_00_0_00_0_00;
  localparam logic [13:0] MUL_S    = 14'b0_1_100_0_00_0_00_0_00;
  localparam logic [13:0] DIV_S    = 14'b0_1_001_0_00_0_00_0_00;
  localparam logic [13:0] MTHI_W   = 14'b0_1_000_1_11_0_00_0_00;
  localparam logic [13:0] MTLO_W   = 14'b0_1_000_0_00_1_11_0_00;
  localparam logic [13:0] MULTU_W  = 14'b0_1_000_1_10_1_10_0_00;
  localparam logic [13:0] DIVU_W   = 14'b0_1_000_1_00_1_00_0_00;
  localparam logic [13:0] DIV_W    = 14'b0_1_000_1_01_1_01_0_00;
  localparam logic [13:0] DONE_V   = 14'b0_1_000_0_00_0_00_1_00;

  muldiv_sequencer #(.MUL_LATENCY(4), .DIV_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .divisor_zero(divisor_zero),
    .div_busy(div_busy), .divu_busy(divu_busy), .op_ready(op_ready), .busy(busy),
    .mul_start(mul_start), .mulu_start(mulu_start), .div_start(div_start),
    .hi_wena(hi_wena), .hi_select(hi_select), .lo_wena(lo_wena), .lo_select(lo_select),
    .done(done), .err_code(err_code)
  );

  assign obs = {op_ready, busy, mul_start, mulu_start, div_start, hi_wena, hi_select, lo_wena, lo_select, done, err_code};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Accept at cycle 0, then compare every cycle; -1 means the event never happens.
  task automatic run_op(input string tag, input logic [2:0] op, input logic dz, input bit hold,
                        input int sc, input logic [13:0] sv, input int wc, input logic [13:0] wv,
                        input int dc, input logic [1:0] ec, input int rst_at,
                        input int bu_lo, input int bu_hi, input int bd_lo, input int bd_hi, input bit tog);
    int last;
    logic [13:0] exp;
    last = (rst_at > 0) ? rst_at + 8 : dc + 1;
    @(negedge clk);
    op_valid = 1'b1;
    op_code = op;
    divisor_zero = dz;
    check({tag, "_ready"}, obs, IDLE_V);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      op_valid = hold && (k <= dc);
      divisor_zero = 1'b0;
      divu_busy = (k >= bu_lo) && (k <= bu_hi);
      div_busy = tog ? k[0] : ((k >= bd_lo) && (k <= bd_hi));
      reset = (rst_at > 0) && (k == rst_at);
      exp = (rst_at > 0 && k > rst_at) ? IDLE_V :
            (k == dc + 1) ? IDLE_V :
            (k == dc) ? (DONE_V | {12'd0, ec}) :
            (k == wc) ? wv :
            (k == sc) ? sv : BUSY_V;
      check($sformatf("%s@%0d", tag, k), obs, exp);
    end
    op_valid = 1'b0;
    reset = 1'b0;
    divu_busy = 1'b0;
    div_busy = 1'b0;
  endtask

  initial begin
    op_valid = 1'b1;
    op_code = 3'b011;
    repeat (2) @(negedge clk);
    check("reset", obs, IDLE_V);
    op_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset", obs, IDLE_V);
    run_op("mthi",    3'b011, 1'b0, 1'b0, -1, BUSY_V, 1, MTHI_W, 2, 2'b00, 0, 0, -1, 0, -1, 1'b0);
    run_op("mtlo",    3'b100, 1'b0, 1'b0, -1, BUSY_V, 1, MTLO_W, 2, 2'b00, 0, 0, -1, 0, -1, 1'b0);
    run_op("multu",   3'b000, 1'b0, 1'b0, 1, MULU_S, 6, MULTU_W, 7, 2'b00, 0, 0, -1, 0, -1, 1'b0);
    run_op("mul",     3'b101, 1'b0, 1'b0, 1, MUL_S, -1, BUSY_V, 6, 2'b00, 0, 0, -1, 0, -1, 1'b0);
    run_op("divu",    3'b001, 1'b0, 1'b0, 1, DIV_S, 36, DIVU_W, 37, 2'b00, 0, 2, 34, 0, -1, 1'b1);
    run_op("div",     3'b010, 1'b0, 1'b0, 1, DIV_S, 8, DIV_W, 9, 2'b00, 0, 2, 40, 2, 6, 1'b0);
    run_op("div_dz",  3'b010, 1'b1, 1'b0, -1, BUSY_V, -1, BUSY_V, 1, 2'b01, 0, 0, -1, 0, -1, 1'b0);
    run_op("divu_dz", 3'b001, 1'b1, 1'b0, -1, BUSY_V, -1, BUSY_V, 1, 2'b01, 0, 0, -1, 0, -1, 1'b0);
    run_op("div_to",  3'b010, 1'b0, 1'b0, 1, DIV_S, -1, BUSY_V, 66, 2'b10, 0, 0, -1, 2, 1000, 1'b0);
    run_op("ill110",  3'b110, 1'b0, 1'b0, -1, BUSY_V, -1, BUSY_V, 1, 2'b11, 0, 0, -1, 0, -1, 1'b0);
    run_op("ill111",  3'b111, 1'b1, 1'b0, -1, BUSY_V, -1, BUSY_V, 1, 2'b11, 0, 0, -1, 0, -1, 1'b0);
    run_op("rst_mid", 3'b000, 1'b0, 1'b0, 1, MULU_S, 6, MULTU_W, 7, 2'b00, 3, 0, -1, 0, -1, 1'b0);
    run_op("hold",    3'b000, 1'b0, 1'b1, 1, MULU_S, 6, MULTU_W, 7, 2'b00, 0, 0, -1, 0, -1, 1'b0);
    run_op("after",   3'b011, 1'b0, 1'b0, -1, BUSY_V, 1, MTHI_W, 2, 2'b00, 0, 0, -1, 0, -1, 1'b0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
